// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared constants and types for the EX-stage multiply/divide
//               unit: MDOp encodings, mfhi/mflo select values used by the
//               decoder, the arithmetic result bundle and a counter-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    // MDOp encodings; 3'b110 and 3'b111 are no-ops.
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    // Decoder select for the mfhi/mflo read mux.
    localparam logic MF_SEL_LO = 1'b0;
    localparam logic MF_SEL_HI = 1'b1;

    // Output of the pure arithmetic core.
    typedef struct packed {
        logic        wr;  // 0 for divide-by-zero: HI/LO must stay untouched
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    // Bits needed to hold max(a, b) in a down-counter.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_core.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_core
// Description : Pure combinational arithmetic for mult/multu/div/divu.
//               Signed ops are done on magnitudes with a single unsigned
//               multiplier and divider, and the signs are fixed up afterwards:
//               quotient negative when operand signs differ, remainder takes
//               the dividend's sign. This also handles 0x80000000 / -1
//               naturally (magnitude 0x80000000 negates to itself).
// Ports       : i_op  - MDOp encoding
//               i_a   - rs operand (dividend / multiplicand)
//               i_b   - rt operand (divisor / multiplier)
//               o_res - {wr, hi, lo}; wr low for divide-by-zero and non-arith
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit_core
    import mul_div_unit_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output md_result_t  o_res
);

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_nz;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_div_b;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;
    logic [31:0] w_quot_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed   = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_a_neg    = w_signed & i_a[31];
    assign w_b_neg    = w_signed & i_b[31];
    assign w_b_nz     = |i_b;

    assign w_a_mag    = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag    = w_b_neg ? (32'd0 - i_b) : i_b;

    assign w_prod_mag = {32'd0, w_a_mag} * {32'd0, w_b_mag};
    assign w_prod     = (w_a_neg ^ w_b_neg) ? (64'd0 - w_prod_mag) : w_prod_mag;

    // Keep the divider away from a zero divisor; the result is discarded anyway.
    assign w_div_b    = w_b_nz ? w_b_mag : 32'd1;
    assign w_quot_mag = w_a_mag / w_div_b;
    assign w_rem_mag  = w_a_mag % w_div_b;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quot_mag) : w_quot_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_rem_mag) : w_rem_mag;

    always_comb begin
        o_res = '0;
        case (i_op)
            MD_MULT, MD_MULTU: begin
                o_res.wr = 1'b1;
                o_res.hi = w_prod[63:32];
                o_res.lo = w_prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                o_res.wr = w_b_nz;
                o_res.hi = w_rem;
                o_res.lo = w_quot;
            end
            default: o_res = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers. The
//               result is computed when the op is accepted and held; busy is
//               then asserted for MULT_CYCLES / DIV_CYCLES cycles and HI/LO are
//               written on the edge where busy drops. mthi/mtlo write at once
//               when idle. Any start while busy is ignored.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               start - EX-stage instruction is an MD op
//               MDOp  - operation select
//               A, B  - rs / rt operands
//               busy  - mult/div in flight
//               HI,LO - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,   // must be >= 1
    parameter int DIV_CYCLES  = 10   // must be >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MULT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_DIV  = c_CNT_W'(DIV_CYCLES);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    md_result_t         r_pend;
    md_result_t         w_core_res;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic w_idle;
    logic w_busy;
    logic w_commit;
    logic w_launch;
    logic w_mthi;
    logic w_mtlo;

    mul_div_unit_core u_core (
        .i_op  (MDOp),
        .i_a   (A),
        .i_b   (B),
        .o_res (w_core_res)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if ((MDOp == MD_MULT) || (MDOp == MD_MULTU)) begin
                        w_state_next = c_ST_MUL;
                    end else if ((MDOp == MD_DIV) || (MDOp == MD_DIVU)) begin
                        w_state_next = c_ST_DIV;
                    end
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_idle   = (r_state == c_ST_IDLE);
        w_busy   = !w_idle;
        w_commit = w_busy && (r_cnt == c_CNT_ONE);
        // Ops 000..011 are exactly those with MDOp[2] clear.
        w_launch = w_idle && start && !MDOp[2];
        w_mthi   = w_idle && start && (MDOp == MD_MTHI);
        w_mtlo   = w_idle && start && (MDOp == MD_MTLO);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_pend <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            if (w_launch) begin
                // MDOp[1] distinguishes div/divu from mult/multu here.
                r_cnt  <= MDOp[1] ? c_CNT_DIV : c_CNT_MULT;
                r_pend <= w_core_res;
            end else if (w_busy) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end

            if (w_commit && r_pend.wr) begin
                r_hi <= r_pend.hi;
                r_lo <= r_pend.lo;
            end

            if (w_mthi) begin
                r_hi <= A;
            end
            if (w_mtlo) begin
                r_lo <= A;
            end
        end
    end

    assign busy = w_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit. Expected HI/LO come from
//               a 64-bit integer reference model of the MIPS HI/LO semantics;
//               busy length is counted cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks;
    int          errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: MIPS HI/LO semantics in plain 64-bit arithmetic.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'b001: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'b010: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'b011: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'b100: m_hi = a;
            3'b101: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int op_cycles(input logic [2:0] op);
        if (op == 3'b000 || op == 3'b001) return MULT_N;
        if (op == 3'b010 || op == 3'b011) return DIV_N;
        return 0;
    endfunction

    // Issue one op for a single cycle and follow it to completion.
    // toggle: scramble A/B during busy; inject: try mthi then mult while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit toggle, input bit inject, input string tag);
        int n;
        int cnt;
        n = op_cycles(op);
        @(negedge clk);
        start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; MDOp = 3'b110;
        if (n == 0) begin
            model_apply(op, a, b);
            check({tag, ".busy"}, {31'd0, busy}, 32'd0);
            check({tag, ".HI"}, HI, m_hi);
            check({tag, ".LO"}, LO, m_lo);
        end else begin
            cnt = 0;
            while (busy === 1'b1 && cnt < 40) begin
                cnt++;
                if (cnt == 1) begin
                    check({tag, ".HI_hold"}, HI, m_hi);
                    check({tag, ".LO_hold"}, LO, m_lo);
                end
                if (toggle) begin
                    A = $urandom; B = $urandom;
                end
                if (inject) begin
                    case (cnt)
                        2: begin start = 1'b1; MDOp = 3'b100; A = 32'h0000_1234; end
                        3: begin MDOp = 3'b000; A = 32'h0000_0005; B = 32'h0000_0007; end
                        4: begin start = 1'b0; MDOp = 3'b110; end
                        default: ;
                    endcase
                end
                @(posedge clk); #1;
            end
            check({tag, ".busy_cycles"}, 32'(cnt), 32'(n));
            model_apply(op, a, b);
            check({tag, ".HI"}, HI, m_hi);
            check({tag, ".LO"}, LO, m_lo);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0; errors = 0;
        m_hi = '0; m_lo = '0;
        reset = 1'b1; start = 1'b0; MDOp = 3'b110; A = '0; B = '0;

        #2;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.HI", HI, 32'd0);
        check("reset.LO", LO, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Directed cases from the plan.
        run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, "mult");
        check("mult.HI_const", HI, 32'hFFFF_FFFF);
        check("mult.LO_const", LO, 32'hFFFF_FFFE);
        run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, "multu_toggle");
        check("multu.HI_const", HI, 32'h0000_0001);
        run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, "div_neg7_2");
        check("div.LO_const", LO, 32'hFFFF_FFFD);
        run_op(3'b011, 32'd7, 32'd2, 1'b0, 1'b0, "divu_7_2");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        check("div_ovf.LO_const", LO, 32'h8000_0000);

        // mthi/mtlo preload, then divide by zero leaves them alone.
        run_op(3'b100, 32'h0000_0011, 32'd0, 1'b0, 1'b0, "mthi");
        run_op(3'b101, 32'h0000_0022, 32'd0, 1'b0, 1'b0, "mtlo");
        run_op(3'b011, 32'd99, 32'd0, 1'b0, 1'b0, "divu_by0");
        check("divu_by0.HI_const", HI, 32'h0000_0011);
        run_op(3'b010, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, "div_by0");

        // Starts while busy are ignored.
        run_op(3'b010, 32'd1000, 32'hFFFF_FFF9, 1'b0, 1'b1, "div_inject");
        // Back-to-back: issued on the cycle right after busy fell.
        run_op(3'b011, 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0, "b2b_divu");
        run_op(3'b000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, "b2b_mult");
        run_op(3'b110, 32'h1234_5678, 32'd1, 1'b0, 1'b0, "noop110");
        run_op(3'b111, 32'h1234_5678, 32'd1, 1'b0, 1'b0, "noop111");

        // Randomized mix.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, ($urandom_range(0, 1) == 1), 1'b0, "rand");
        end

        // Async reset in the middle of a mult.
        run_op(3'b100, 32'h0000_AAAA, 32'd0, 1'b0, 1'b0, "pre_rst_mthi");
        run_op(3'b101, 32'h0000_5555, 32'd0, 1'b0, 1'b0, "pre_rst_mtlo");
        @(negedge clk);
        start = 1'b1; MDOp = 3'b000; A = 32'd9; B = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; MDOp = 3'b110;
        check("rst_mid.busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        check("rst_mid.busy", {31'd0, busy}, 32'd0);
        check("rst_mid.HI", HI, 32'd0);
        check("rst_mid.LO", LO, 32'd0);
        @(negedge clk); reset = 1'b0;
        run_op(3'b001, 32'd3, 32'd4, 1'b0, 1'b0, "post_rst_multu");
        check("post_rst.LO_const", LO, 32'd12);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit beside the combinational ALU in the EX stage of the pipelined MIPS core.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the HI/LO registers that mfhi/mflo read.
- Asserts busy so the hazard unit can stall any later MD-class instruction until HI/LO are final.

Parameters:
- MULT_CYCLES, 5, number of cycles busy is high for mult/multu.
- DIV_CYCLES, 10, number of cycles busy is high for div/divu.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  EX-stage instruction is an MD op; sampled on the rising edge.
- MDOp  input  3  op select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op.
- A  input  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- B  input  32  rt operand (divisor / multiplier).
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  HI register (remainder / upper product).
- LO  output  32  LO register (quotient / lower product).

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, HI=0, LO=0, cycle counter=0, pending result discarded.
- Idle, start=1 and MDOp in 000..011, sampled at edge T0:
  - A, B and MDOp are latched internally; later changes on A/B have no effect.
  - busy=1 after T0 and stays high for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES).
  - At edge TN, HI/LO are written and busy drops to 0 in the same edge.
  - HI/LO keep their old values during the busy window.
- Result computation: may be done at latch time and held, or computed iteratively; only the timing at the ports is specified.
- mult: signed 32x32 -> 64; HI=product[63:32], LO=product[31:0].
- multu: same split, unsigned.
- div (signed):
  - LO=quotient truncated toward zero; HI=remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- divu: LO=A/B, HI=A%B, unsigned.
- Divide by zero (div or divu, B=0): HI and LO are left unchanged; busy still runs the full DIV_CYCLES.
- mthi/mtlo, idle, start=1: HI (or LO) <= A at that edge; busy stays 0; zero latency.
- start=1 while busy=1: ignored for every MDOp, including mthi/mtlo. The stall logic must prevent this; the unit does not queue.
- MDOp 110/111 with start=1: no state change.
- Back-to-back: if busy falls at TN and start=1 is sampled at TN+1, the new op begins normally with no bubble beyond that one cycle.
- Counter: internal down-counter, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)); no wrap can occur.
- FSM states:
  - IDLE -> MUL on start with 000/001.
  - IDLE -> DIV on start with 010/011.
  - MUL/DIV -> IDLE when the counter reaches 1 at an edge (the commit edge).
  - reset -> IDLE from any state.

Decomposition:
- Shared package: MDOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO); the decoder's mfhi/mflo select constants also live here.
- No sub-module required.
- An optional md_core (pure arithmetic: A, B, op -> hi, lo) may be split out so the arithmetic can be unit-tested separately from timing.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002, one-cycle start -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; A/B toggled randomly during busy has no effect.
- div, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu, A=7, B=2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via mthi/mtlo (each visible the next cycle, busy never rises); then divu B=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
- During a div busy window: start with mthi A=0x1234, then start with mult -> both ignored; final HI/LO equal the div result; busy falls on cycle 10.
- Assert reset asynchronously at cycle 3 of a mult -> busy, HI and LO go to 0 immediately, without waiting for a clock edge; after release, a fresh multu 3*4 gives LO=12, HI=0.
